// File: rtl/apex_pkg.sv
// apex_pkg: shared types and constants for the APEX execution monitor.
// Holds the monitor state encoding, the metadata word offsets and the
// default location of the metadata register window on the peripheral bus.
package apex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } apex_state_t;

  // Word offsets of the bound registers relative to the metadata base
  localparam logic [1:0] META_ERMIN = 2'd0;
  localparam logic [1:0] META_ERMAX = 2'd1;
  localparam logic [1:0] META_ORMIN = 2'd2;
  localparam logic [1:0] META_ORMAX = 2'd3;

  localparam logic [13:0] META_BASE_DEFAULT  = 14'h00b0;
  localparam int unsigned META_WORDS_DEFAULT = 32'(META_ORMAX) + 32'd1;

endpackage

// File: rtl/apex_range_check.sv
// apex_range_check: combinational unsigned inclusive window test
// (lo <= addr <= hi). An empty window (lo > hi) never matches.
module apex_range_check (
  input  logic [15:0] addr,
  input  logic [15:0] lo,
  input  logic [15:0] hi,
  output logic        in_range
);

  assign in_range = (addr >= lo) && (addr <= hi);

endmodule

// File: rtl/apex_exec_monitor.sv
// apex_exec_monitor: produces exec_flag, high only while an uninterrupted,
// unmodified execution of ER is in effect (state RUN) or has completed
// cleanly (state DONE).
// Optional build macro: APEX_IRQ_CHECK_EN -- when defined, an interrupt
// taken while in RUN counts as a violation.
module apex_exec_monitor
  import apex_pkg::*;
#(
  parameter logic [13:0] META_BASE  = META_BASE_DEFAULT,
  parameter int unsigned META_WORDS = META_WORDS_DEFAULT
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [14:0] dma_addr,
  input  logic        dma_en,
  input  logic [13:0] per_addr,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        irq,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic [15:0] OR_min,
  input  logic [15:0] OR_max,
  output logic        exec_flag
);

  // Metadata window on the peripheral bus, widened so base+words cannot wrap
  localparam logic [14:0] META_LO = {1'b0, META_BASE};
  localparam logic [14:0] META_HI = {1'b0, META_BASE} + 15'(META_WORDS);

  apex_state_t state_r;
  apex_state_t state_nxt_s;
  logic [15:0] prev_pc_r;
  logic        exec_flag_r;

  logic        pc_in_er_s;
  logic        data_in_er_s;
  logic        data_in_or_s;
  logic        dma_in_er_s;
  logic        dma_in_or_s;
  logic [15:0] dma_byte_addr_s;
  logic        cpu_wr_s;
  logic        per_wr_s;
  logic        per_meta_s;
  logic        meta_ok_s;
  logic        exit_ok_s;
  logic        irq_viol_s;
  logic        viol_s;

  assign dma_byte_addr_s = {dma_addr, 1'b0};

  apex_range_check u_pc_er   (.addr(pc),              .lo(ER_min), .hi(ER_max), .in_range(pc_in_er_s));
  apex_range_check u_data_er (.addr(data_addr),       .lo(ER_min), .hi(ER_max), .in_range(data_in_er_s));
  apex_range_check u_data_or (.addr(data_addr),       .lo(OR_min), .hi(OR_max), .in_range(data_in_or_s));
  apex_range_check u_dma_er  (.addr(dma_byte_addr_s), .lo(ER_min), .hi(ER_max), .in_range(dma_in_er_s));
  apex_range_check u_dma_or  (.addr(dma_byte_addr_s), .lo(OR_min), .hi(OR_max), .in_range(dma_in_or_s));

  assign cpu_wr_s   = data_en & data_wr;
  assign per_wr_s   = per_en & (|per_we);
  assign per_meta_s = ({1'b0, per_addr} >= META_LO) && ({1'b0, per_addr} < META_HI);
  assign meta_ok_s  = (ER_min <= ER_max) && (OR_min <= OR_max);
  // Leaving ER is only legal from its last instruction word
  assign exit_ok_s  = (prev_pc_r == ER_max);

`ifdef APEX_IRQ_CHECK_EN
  assign irq_viol_s = irq & (state_r == RUN);
`else
  // Interrupts are tolerated; handlers outside ER still hit the exit rule
  assign irq_viol_s = 1'b0 & irq;
`endif

  assign viol_s = (cpu_wr_s & data_in_er_s)
                | (cpu_wr_s & data_in_or_s & ~pc_in_er_s)
                | (dma_en & (dma_in_er_s | dma_in_or_s))
                | (per_wr_s & per_meta_s)
                | ((state_r == RUN) & ~pc_in_er_s & ~exit_ok_s)
                | irq_viol_s;

  // Next-state selection: violations and bad bounds override everything
  always_comb begin
    state_nxt_s = state_r;
    if (!meta_ok_s || viol_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (pc == ER_min) state_nxt_s = RUN;
          else              state_nxt_s = IDLE;
        end
        RUN: begin
          if (!pc_in_er_s && exit_ok_s) state_nxt_s = DONE;
          else                          state_nxt_s = RUN;
        end
        DONE: begin
          if (pc == ER_min) state_nxt_s = RUN;
          else              state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, previous-pc and flag registers
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r     <= IDLE;
      prev_pc_r   <= 16'h0000;
      exec_flag_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prev_pc_r   <= pc;
      exec_flag_r <= (state_nxt_s != IDLE);
    end
  end

  assign exec_flag = exec_flag_r;

endmodule

// File: doc/apex_exec_monitor.md
# apex_exec_monitor

Hardware monitor that produces the VAPE `exec_flag` consumed by the metadata register block. It tracks the CPU program counter, data bus, DMA bus and peripheral bus against the ER/OR bounds that the metadata block exports. It asserts `exec_flag` only while an uninterrupted, unmodified execution of ER, with writes to OR confined to ER code, is in effect. It sits between the openMSP430 core taps and the metadata block's `exec_flag` input.

## Interface
- `META_BASE`, 14'h0b0: word address of the ER_min register (ER_min, ER_max, OR_min, OR_max at +0..+3).
- `META_WORDS`, 4: number of protected metadata words.
- `mclk` input 1: main system clock.
- `puc_rst` input 1: reset, asynchronous, active-high.
- `pc` input 16: current instruction address from the core.
- `data_addr` input 16: CPU data bus byte address.
- `data_en` input 1: CPU data access valid.
- `data_wr` input 1: CPU data access is a write.
- `dma_addr` input 15: DMA word address.
- `dma_en` input 1: DMA access valid.
- `per_addr` input 14: peripheral word address.
- `per_en` input 1: peripheral enable.
- `per_we` input 2: peripheral byte write enables.
- `irq` input 1: any interrupt taken by the core.
- `ER_min`, `ER_max`, `OR_min`, `OR_max` input 16 each: bounds from the metadata block.
- `exec_flag` output 1: registered; 1 in RUN or DONE.

## Operation
- States: IDLE (0), RUN (1), DONE (2). Encoding lives in the package. `exec_flag = (state != IDLE)`.
- `prev_pc` register holds the previous cycle's `pc`.
- `in_er = ER_min <= pc <= ER_max`, unsigned, inclusive. `in_or`, `dma_er` and `dma_or` use the same rule; DMA uses `{dma_addr,1'b0}`.
- `meta_ok = (ER_min <= ER_max) & (OR_min <= OR_max)`.
- `viol` is the OR of:
  - CPU write with `data_addr` in ER.
  - CPU write in OR while `!in_er`.
  - Any DMA access with `dma_er | dma_or`.
  - Peripheral write (`per_en & |per_we`) with `META_BASE <= per_addr < META_BASE+META_WORDS`.
  - In RUN only: `!in_er & prev_pc != ER_max` (illegal exit).
  - In RUN only: `!in_er & prev_pc == ER_max & pc != prev_pc+2`? No — legal exit is any `!in_er` with `prev_pc == ER_max`.
  - `irq` in RUN, if enabled (see Configuration).
- Transitions, checked in priority order:
  - `!meta_ok | viol` → IDLE, from any state.
  - IDLE: `pc == ER_min` → RUN.
  - RUN: `!in_er & prev_pc == ER_max` → DONE; otherwise stay in RUN. Jumps back to ER_min inside ER stay in RUN.
  - DONE: `pc == ER_min` → RUN (fresh execution); otherwise stay in DONE.
- Violation beats entry in the same cycle: IDLE stays IDLE.
- Entry is only possible at exactly ER_min. Entry mid-ER leaves the block in IDLE.

## Timing
- Reset: state IDLE, `exec_flag` 0, `prev_pc` 16'h0000.
- `exec_flag` is registered. It rises on the first mclk edge after the cycle in which `pc == ER_min` and falls on the edge after a violating cycle. Latency is 1 cycle in both directions.
- The first cycle after reset has `prev_pc` = 0. An illegal-exit check cannot fire because the state is IDLE.
- Bound changes apply combinationally in the same cycle. A bound change through the peripheral bus is itself a violation.
- `puc_rst` asserted mid-RUN forces IDLE asynchronously; there is no resume.
- `ER_min == ER_max` is legal: a single-word ER enters RUN, and any following `!in_er` pc goes to DONE.
- Addresses 16'hFFFF and 16'h0000 are ordinary values; there is no wrap-around arithmetic except `prev_pc` compare.

## Configuration
- `APEX_IRQ_CHECK_EN` defined: `irq` while in RUN is a violation and moves the block to IDLE.
- Undefined: `irq` is ignored. Interrupt handlers outside ER still trip the illegal-exit rule unless entered from ER_max.

## Structure
- Package `apex_pkg`: state enum `apex_state_t` (IDLE/RUN/DONE), metadata word offsets `META_ERMIN..META_ORMAX`, default `META_BASE`.
- Sub-module `apex_range_check`: combinational inclusive 16-bit `lo <= addr <= hi`. Instantiated for `pc`/ER, `data`/ER, `data`/OR, `dma`/ER and `dma`/OR.

## Test plan
- ER=0xE000..0xE0FE, OR=0x0200..0x02FE; `pc` walks 0xE000→0xE0FE→0xC000 → `exec_flag` 0→1 one cycle after 0xE000, stays 1 after exit (DONE).
- Same bounds; `pc` 0xE000→0xE010→0xC000 → `exec_flag` falls to 0 one cycle after 0xC000 (illegal exit).
- In DONE, CPU write `data_addr`=0x0210 with `pc`=0xC000 → `exec_flag` 0; a write to 0x0210 from `pc`=0xE020 in RUN keeps it 1.
- In RUN, peripheral write `per_addr`=0x0b1 → 0; DMA read `dma_addr`=0x7008 (0xE010) → 0.
- `pc`=0xE000 and CPU write to 0xE004 in the same cycle → `exec_flag` stays 0. Bounds ER_min=0xE100 > ER_max=0xE000 → never asserts.
- `irq` pulse in RUN → 0 with `APEX_IRQ_CHECK_EN` defined, stays 1 without. `puc_rst` mid-RUN → 0 immediately.
